// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port memory: round-robin on ties,
// latches the winning request, and holds the memory port until ready or timeout.
module mem_port_arbiter #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic              we0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              done0,

    input  logic              req1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic              we1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              done1,

    output logic [DWIDTH-1:0] rdata,
    output logic              err,
    output logic              sel,
    output logic              busy,

    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              state_dbg
);

    // Handshake: a requester holds req (with stable addr/we/wdata) until it sees
    // its one-cycle done pulse; rdata and err are valid only alongside done.
    // mem_req is held for the whole access and mem_ready is a one-cycle ack
    // that is only honoured while an access is in flight.

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    logic              sel_n;
    logic              busy_n;
    logic              mem_req_n;
    logic [AWIDTH-1:0] mem_addr_n;
    logic              mem_we_n;
    logic [DWIDTH-1:0] mem_wdata_n;
    logic [DWIDTH-1:0] rdata_n;
    logic              done0_n;
    logic              done1_n;
    logic              err_n;

    logic              elig0;
    logic              elig1;
    logic              win;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            sel        <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            rdata      <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            busy       <= busy_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            mem_we     <= mem_we_n;
            mem_wdata  <= mem_wdata_n;
            rdata      <= rdata_n;
            done0      <= done0_n;
            done1      <= done1_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        sel_n        = sel;
        busy_n       = busy;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;
        mem_we_n     = mem_we;
        mem_wdata_n  = mem_wdata;
        rdata_n      = rdata;
        done0_n      = 1'b0;
        done1_n      = 1'b0;
        err_n        = 1'b0;

        // The requester being told "done" this cycle may still show req high
        // while it reacts; masking it avoids serving the same request twice.
        elig0 = req0 & ~done0;
        elig1 = req1 & ~done1;
        win   = (elig0 & elig1) ? ~last_grant : elig1;

        unique case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    sel_n       = win;
                    mem_addr_n  = win ? addr1  : addr0;
                    mem_we_n    = win ? we1    : we0;
                    mem_wdata_n = win ? wdata1 : wdata0;
                    mem_req_n   = 1'b1;
                    busy_n      = 1'b1;
                    cnt_n       = '0;
                    state_n     = ACCESS;
                end
            end

            ACCESS: begin
                if (mem_ready) begin
                    rdata_n      = mem_rdata;
                    done0_n      = ~sel;
                    done1_n      = sel;
                    mem_req_n    = 1'b0;
                    busy_n       = 1'b0;
                    last_grant_n = sel;
                    state_n      = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Abort keeps the previous rdata; err flags the bad completion.
                    done0_n      = ~sel;
                    done1_n      = sel;
                    err_n        = 1'b1;
                    mem_req_n    = 1'b0;
                    busy_n       = 1'b0;
                    last_grant_n = sel;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port memory between two requesters: requester 0 is instruction fetch and requester 1 is load/store.
- Round-robin arbitration on ties.
- Latches the winner's address, write enable and write data, then drives the memory port until the memory acknowledges or a timeout expires.
- Drives the select of the shared memory-port mux and reports completion or error back to the served requester.

Parameters:
- DWIDTH, 32, data width of wdata/rdata.
- AWIDTH, 32, address width.
- TIMEOUT, 15, max ACCESS cycles waiting for mem_ready before abort (1..2^CNT_W-1).
- CNT_W, 4, timeout counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 access request, level.
- addr0  input  AWIDTH  requester 0 address.
- we0  input  1  requester 0 write enable.
- wdata0  input  DWIDTH  requester 0 write data.
- done0  output  1  one-cycle pulse: requester 0 access complete or aborted.
- req1, addr1, we1, wdata1, done1  same as above, for requester 1.
- rdata  output  DWIDTH  registered read data, valid while done0/done1 is high.
- err  output  1  one-cycle pulse coincident with done on timeout abort.
- sel  output  1  index of the requester currently or last granted; drives the shared mux select.
- busy  output  1  high in ACCESS.
- mem_req  output  1  memory request, held through the access.
- mem_addr  output  AWIDTH  latched address.
- mem_we  output  1  latched write enable.
- mem_wdata  output  DWIDTH  latched write data.
- mem_rdata  input  DWIDTH  memory read data, valid when mem_ready is high.
- mem_ready  input  1  memory acknowledge, single cycle.

Behaviour:
- Reset (async, immediate) clears the following:
  - State = IDLE.
  - mem_req, mem_we, done0, done1, err, busy = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - sel = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
- All outputs are registered.
- IDLE state:
  - Eligible requester = req high AND its done output is not high this cycle. This masks the requester just served, preventing a double-serve while it drops req.
  - One eligible requester wins outright.
  - Both eligible: the winner is the one not equal to last_grant.
  - On a winner at an edge:
    - sel <= winner.
    - Latch winner's addr/we/wdata onto mem_addr/mem_we/mem_wdata.
    - mem_req <= 1, busy <= 1, counter <= 0.
    - Go to ACCESS.
  - No eligible requester: stay in IDLE, mem_req stays 0.
- ACCESS state:
  - mem_addr/mem_we/mem_wdata/sel are held stable.
  - Input changes on req/addr/we/wdata are ignored, including req dropping; the access completes regardless.
  - If mem_ready is high at an edge:
    - rdata <= mem_rdata (also captured on writes; don't-care for writes).
    - done[sel] <= 1 for one cycle.
    - mem_req <= 0, busy <= 0, last_grant <= sel.
    - Go to IDLE.
  - Else if counter == TIMEOUT-1:
    - Abort: done[sel] <= 1, err <= 1, mem_req <= 0, busy <= 0.
    - rdata holds its previous value.
    - last_grant <= sel.
    - Go to IDLE.
  - Else counter increments.
  - mem_ready outside ACCESS is ignored.
- Latency:
  - Request sampled at edge E; mem_req is high after E.
  - With mem_ready high in the first ACCESS cycle, done is high after E+1 (2 cycles from req to done).
  - Back-to-back grants: a new grant is possible at the edge following the done cycle. Requester 1 waiting during a requester 0 access is granted at that edge.
- done0 and done1 are never high simultaneously. done and mem_req are never both high.
- A reset asserted mid-ACCESS aborts silently: no done, no err, mem_req drops asynchronously.

Test Plan:
1. Reset, then req0=1, addr0=0x00000040, we0=0. Memory returns mem_ready=1 with mem_rdata=0xDEADBEEF on the first ACCESS cycle -> mem_req high 1 cycle, mem_addr=0x40, sel=0; done0 pulses 2 cycles after req, rdata=0xDEADBEEF, err=0.
2. req0 and req1 raised in the same cycle, both held, 1-wait-state memory -> requester 0 served first. Requester 1 is granted at the edge after done0 (sel=1, mem_addr=addr1). After req0 is re-raised, ties alternate 0,1,0,1.
3. req1=1, we1=1, addr1=0x100, wdata1=0x12345678, 3 wait states -> mem_we=1 and mem_wdata=0x12345678 held stable 4 cycles. wdata1 changed mid-access has no effect on mem_wdata. done1 pulses once.
4. req0 with mem_ready never asserted, TIMEOUT=15 -> mem_req high exactly 15 cycles, then done0=err=1 for one cycle, rdata unchanged, state IDLE. A subsequent req1 is granted normally.
5. Assert rst during ACCESS (req0, mem_ready low) -> mem_req, busy, sel drop immediately and no done0/err pulse. After release, a held req0 is re-arbitrated and completes.
6. req0 held high across done0 while req1 is idle -> no second access started in the done0 cycle. A new access starts at the following edge (requester intentionally re-requesting).
